decode_stage: RTL and testbench

Instruction-decode pipeline stage directly upstream of the 32×64-bit register bank. It does three things:
- Decodes a 32-bit RV64I instruction.
- Drives the bank's two read addresses and captures the returned operands.
- Registers operands, sign-extended immediate and control fields for the execute stage.

A 32-entry busy scoreboard stalls read-after-write hazards until the writeback stage retires the producing instruction.

---
 rtl/decode_stage_if.sv | 54 +++++
 rtl/decode_stage.sv | 194 +++++++++++++++++++
 tb/tb_decode_stage.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// ============================================================================
//  Module      : decode_stage_if
//  Description : Bundle of the decode stage's fetch, bank, writeback and
//                execute-side signals, seen from both ends.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface decode_stage_if #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [REG_ADDR_W-1:0] register1;
    logic [REG_ADDR_W-1:0] register2;
    logic [XLEN-1:0]       dataout1;
    logic [XLEN-1:0]       dataout2;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_rs1_val;
    logic [XLEN-1:0]       out_rs2_val;
    logic [XLEN-1:0]       out_imm;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_regwrite;
    logic [6:0]            out_opcode;
    logic [2:0]            out_funct3;
    logic [6:0]            out_funct7;
    logic                  out_illegal;

    // Environment side: fetch, register bank, writeback and execute.
    modport master (
        output in_valid, in_instr, dataout1, dataout2,
               wb_valid, wb_rd, wb_data, out_ready,
        input  in_ready, register1, register2, out_valid,
               out_rs1_val, out_rs2_val, out_imm, out_rd, out_regwrite,
               out_opcode, out_funct3, out_funct7, out_illegal
    );

    // Decode stage side.
    modport slave (
        input  in_valid, in_instr, dataout1, dataout2,
               wb_valid, wb_rd, wb_data, out_ready,
        output in_ready, register1, register2, out_valid,
               out_rs1_val, out_rs2_val, out_imm, out_rd, out_regwrite,
               out_opcode, out_funct3, out_funct7, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
//  Module      : decode_stage
//  Description : RV64I decode stage with operand capture and a busy-register
//                scoreboard. Optional writeback bypass: DECODE_WB_BYPASS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    localparam int         c_NREG     = 1 << REG_ADDR_W;
    localparam logic [6:0] c_OP_OP    = 7'b0110011;
    localparam logic [6:0] c_OP_OP32  = 7'b0111011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [6:0]            w_funct7;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic                  w_fmt_r, w_fmt_i, w_fmt_s, w_fmt_b, w_fmt_u, w_fmt_j;
    logic                  w_illegal;
    logic                  w_uses_rs1, w_uses_rs2;
    logic                  w_regwrite;
    logic [31:0]           w_imm32;
    logic [XLEN-1:0]       w_imm;
    logic                  w_byp1, w_byp2;
    logic                  w_hazard;
    logic                  w_in_ready;
    logic                  w_accept;
    logic [XLEN-1:0]       w_op1, w_op2;
    logic [c_NREG-1:0]     w_busy_nxt;

    logic [c_NREG-1:0]     r_busy;
    logic                  r_out_valid;
    logic [XLEN-1:0]       r_rs1_val;
    logic [XLEN-1:0]       r_rs2_val;
    logic [XLEN-1:0]       r_imm;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_regwrite;
    logic [6:0]            r_opcode;
    logic [2:0]            r_funct3;
    logic [6:0]            r_funct7;
    logic                  r_illegal;

    assign w_opcode = bus.in_instr[6:0];
    assign w_rd     = bus.in_instr[11:7];
    assign w_funct3 = bus.in_instr[14:12];
    assign w_rs1    = bus.in_instr[19:15];
    assign w_rs2    = bus.in_instr[24:20];
    assign w_funct7 = bus.in_instr[31:25];

    always_comb begin
        w_fmt_r = 1'b0;
        w_fmt_i = 1'b0;
        w_fmt_s = 1'b0;
        w_fmt_b = 1'b0;
        w_fmt_u = 1'b0;
        w_fmt_j = 1'b0;
        case (w_opcode)
            c_OP_OP, c_OP_OP32:                         w_fmt_r = 1'b1;
            c_OP_IMM, c_OP_IMM32, c_OP_LOAD, c_OP_JALR: w_fmt_i = 1'b1;
            c_OP_STORE:                                 w_fmt_s = 1'b1;
            c_OP_BR:                                    w_fmt_b = 1'b1;
            c_OP_LUI, c_OP_AUIPC:                       w_fmt_u = 1'b1;
            c_OP_JAL:                                   w_fmt_j = 1'b1;
            default:                                    ;
        endcase
    end

    assign w_illegal  = !(w_fmt_r | w_fmt_i | w_fmt_s | w_fmt_b | w_fmt_u | w_fmt_j);
    assign w_uses_rs1 = w_fmt_r | w_fmt_i | w_fmt_s | w_fmt_b;
    assign w_uses_rs2 = w_fmt_r | w_fmt_s | w_fmt_b;
    assign w_regwrite = (w_fmt_r | w_fmt_i | w_fmt_u | w_fmt_j) && (w_rd != '0);

    always_comb begin
        w_imm32 = '0;
        if (w_fmt_i) begin
            w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        end else if (w_fmt_s) begin
            w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
        end else if (w_fmt_b) begin
            w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[7], bus.in_instr[30:25],
                       bus.in_instr[11:8], 1'b0};
        end else if (w_fmt_u) begin
            w_imm32 = {bus.in_instr[31:12], 12'h000};
        end else if (w_fmt_j) begin
            w_imm32 = {{12{bus.in_instr[31]}}, bus.in_instr[19:12], bus.in_instr[20],
                       bus.in_instr[30:21], 1'b0};
        end
    end

    assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};

`ifdef DECODE_WB_BYPASS_EN
    // A source being retired this very cycle is forwarded rather than stalled on.
    assign w_byp1 = w_uses_rs1 && bus.wb_valid && (bus.wb_rd == w_rs1) && (w_rs1 != '0);
    assign w_byp2 = w_uses_rs2 && bus.wb_valid && (bus.wb_rd == w_rs2) && (w_rs2 != '0);
    assign w_op1  = w_byp1 ? bus.wb_data : bus.dataout1;
    assign w_op2  = w_byp2 ? bus.wb_data : bus.dataout2;
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
    assign w_op1  = bus.dataout1;
    assign w_op2  = bus.dataout2;
`endif

    assign w_hazard   = bus.in_valid &&
                        ((w_uses_rs1 && r_busy[w_rs1] && !w_byp1) ||
                         (w_uses_rs2 && r_busy[w_rs2] && !w_byp2));
    assign w_in_ready = !rst && !w_hazard && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Set after clear so a same-cycle retire/issue of one register stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.wb_valid) begin
            w_busy_nxt[bus.wb_rd] = 1'b0;
        end
        if (w_accept && w_regwrite) begin
            w_busy_nxt[w_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_regwrite  <= 1'b0;
            r_opcode    <= '0;
            r_funct3    <= '0;
            r_funct7    <= '0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_rs1_val   <= w_op1;
            r_rs2_val   <= w_op2;
            r_imm       <= w_imm;
            r_rd        <= w_rd;
            r_regwrite  <= w_regwrite;
            r_opcode    <= w_opcode;
            r_funct3    <= w_funct3;
            r_funct7    <= w_funct7;
            r_illegal   <= w_illegal;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.register1    = w_rs1;
    assign bus.register2    = w_rs2;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_rs1_val  = r_rs1_val;
    assign bus.out_rs2_val  = r_rs2_val;
    assign bus.out_imm      = r_imm;
    assign bus.out_rd       = r_rd;
    assign bus.out_regwrite = r_regwrite;
    assign bus.out_opcode   = r_opcode;
    assign bus.out_funct3   = r_funct3;
    assign bus.out_funct7   = r_funct7;
    assign bus.out_illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage against a format-level
//                reference decoder and a set-based busy model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] rs1v;
        logic [63:0] rs2v;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
    } bundle_t;

    logic clk = 1'b0;
    logic rst;
    logic bank_clear;
    logic [63:0] bank [32];

    decode_stage_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

    decode_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.dataout1 = bank[bus.register1];
    assign bus.dataout2 = bank[bus.register2];

    always @(posedge clk) begin
        if (bank_clear) begin
            for (int i = 0; i < 32; i++) bank[i] <= (i == 0) ? 64'd0 : {$urandom, $urandom};
        end else if (bus.wb_valid && bus.wb_rd != 5'd0) begin
            bank[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Reference state
    logic [31:0] m_busy;
    bit          m_valid;
    bundle_t     m_out;
    bit          last_acc;
    int          total = 0;
    int          bad   = 0;

    function automatic byte ref_fmt(logic [6:0] op);
        case (op)
            7'h33, 7'h3B:               return "R";
            7'h13, 7'h1B, 7'h03, 7'h67: return "I";
            7'h23:                      return "S";
            7'h63:                      return "B";
            7'h37, 7'h17:               return "U";
            7'h6F:                      return "J";
            default:                    return "X";
        endcase
    endfunction

    function automatic bundle_t ref_decode(logic [31:0] ins);
        bundle_t b;
        byte     f;
        b    = '0;
        f    = ref_fmt(ins[6:0]);
        b.op = ins[6:0];
        b.f3 = ins[14:12];
        b.f7 = ins[31:25];
        b.rd = ins[11:7];
        case (f)
            "I": b.imm = 64'($signed(ins) >>> 20);
            "S": b.imm = 64'($signed({ins[31:25], ins[11:7]}));
            "B": b.imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            "U": b.imm = 64'($signed({ins[31:12], 12'h000}));
            "J": b.imm = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default: b.imm = 64'd0;
        endcase
        b.rw  = (f == "R" || f == "I" || f == "U" || f == "J") && (ins[11:7] != 5'd0);
        b.ill = (f == "X");
        return b;
    endfunction

    function automatic bit uses1(logic [31:0] ins);
        byte f = ref_fmt(ins[6:0]);
        return f == "R" || f == "I" || f == "S" || f == "B";
    endfunction

    function automatic bit uses2(logic [31:0] ins);
        byte f = ref_fmt(ins[6:0]);
        return f == "R" || f == "S" || f == "B";
    endfunction

    function automatic bit fwd(logic [4:0] rs);
        return BYP && bus.wb_valid && bus.wb_rd == rs && rs != 5'd0;
    endfunction

    function automatic bit model_ready();
        logic [4:0] a, b;
        bit h;
        a = bus.in_instr[19:15];
        b = bus.in_instr[24:20];
        h = bus.in_valid && ((uses1(bus.in_instr) && m_busy[a] && !fwd(a)) ||
                             (uses2(bus.in_instr) && m_busy[b] && !fwd(b)));
        return !rst && !h && (!m_valid || bus.out_ready);
    endfunction

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b.rs1v = bus.out_rs1_val;
        b.rs2v = bus.out_rs2_val;
        b.imm  = bus.out_imm;
        b.rd   = bus.out_rd;
        b.rw   = bus.out_regwrite;
        b.op   = bus.out_opcode;
        b.f3   = bus.out_funct3;
        b.f7   = bus.out_funct7;
        b.ill  = bus.out_illegal;
        return b;
    endfunction

    // Advance one clock and move the reference state with it.
    task automatic step();
        bit acc;
        bit nv;
        bundle_t nb;
        logic [31:0] nbusy;
        logic [4:0] a, b;
        acc   = bus.in_valid && model_ready();
        nv    = m_valid;
        nb    = m_out;
        nbusy = m_busy;
        a     = bus.in_instr[19:15];
        b     = bus.in_instr[24:20];
        if (rst) begin
            nv = 1'b0;
            nb = '0;
            nbusy = '0;
        end else begin
            if (bus.wb_valid) nbusy[bus.wb_rd] = 1'b0;
            if (acc) begin
                nb      = ref_decode(bus.in_instr);
                nb.rs1v = (uses1(bus.in_instr) && fwd(a)) ? bus.wb_data : bank[a];
                nb.rs2v = (uses2(bus.in_instr) && fwd(b)) ? bus.wb_data : bank[b];
                nv      = 1'b1;
                if (nb.rw) nbusy[nb.rd] = 1'b1;
            end else if (bus.out_ready) begin
                nv = 1'b0;
            end
        end
        nbusy[0] = 1'b0;
        @(posedge clk);
        m_valid  = nv;
        m_out    = nb;
        m_busy   = nbusy;
        last_acc = acc;
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 64'd0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bank_clear = 1'b1;
        m_busy = '0; m_valid = 1'b0; m_out = '0; last_acc = 1'b0;
        drive_idle();
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        step();
        step();
        bank_clear = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++;
        if (dut_bundle() !== bundle_t'(0)) begin bad++; $display("FAIL reset_fields: got %h want 0", dut_bundle()); end
        rst = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_addi();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00500093;
        #1;
        total++;
        if (bus.register1 !== 5'd0) begin bad++; $display("FAIL addi_register1: got %0d want 0", bus.register1); end
        step();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", bus.out_valid); end
        total++;
        if ({bus.out_rd, bus.out_imm, bus.out_regwrite} !== {5'd1, 64'd5, 1'b1})
            begin bad++; $display("FAIL addi_fields: got rd=%0d imm=%h rw=%b want rd=1 imm=5 rw=1",
                                  bus.out_rd, bus.out_imm, bus.out_regwrite); end
    endtask

    // Consumer of x1 stalls until x1 is retired.
    task automatic test_raw_stall();
        logic [63:0] wbv = {$urandom, $urandom};
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00108133;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL raw_stall_ready: got %b want 0", bus.in_ready); end
            step();
        end
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = wbv;
        #1;
        total++;
        if (bus.in_ready !== BYP) begin bad++; $display("FAIL raw_wb_cycle_ready: got %b want %b", bus.in_ready, BYP); end
        step();
        bus.wb_valid = 1'b0;
        for (int k = 0; k < 3 && !last_acc; k++) begin
            #1;
            total++;
            if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL raw_after_wb_ready: got %b want 1", bus.in_ready); end
            step();
        end
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.out_rd} !== {1'b1, 5'd2}) begin bad++; $display("FAIL raw_out: got v=%b rd=%0d want v=1 rd=2", bus.out_valid, bus.out_rd); end
        total++;
        if ({bus.out_rs1_val, bus.out_rs2_val} !== {wbv, wbv})
            begin bad++; $display("FAIL raw_operands: got %h %h want %h", bus.out_rs1_val, bus.out_rs2_val, wbv); end
    endtask

    task automatic test_neg_imm();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hFFF00193;
        #1;
        step();
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.out_rd, bus.out_imm} !== {1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF})
            begin bad++; $display("FAIL neg_imm: got v=%b rd=%0d imm=%h want v=1 rd=3 imm=all ones", bus.out_valid, bus.out_rd, bus.out_imm); end
    endtask

    task automatic test_store();
        logic [63:0] wbv = {$urandom, $urandom};
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h0020A423;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL store_stall: got %b want 0", bus.in_ready); end
        step();
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = wbv;
        #1;
        total++;
        if (bus.in_ready !== BYP) begin bad++; $display("FAIL store_wb_cycle_ready: got %b want %b", bus.in_ready, BYP); end
        step();
        bus.wb_valid = 1'b0;
        for (int k = 0; k < 3 && !last_acc; k++) begin
            #1;
            step();
        end
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.out_regwrite, bus.out_imm, bus.out_rs2_val} !== {1'b1, 1'b0, 64'd8, wbv})
            begin bad++; $display("FAIL store_out: got v=%b rw=%b imm=%h rs2=%h want v=1 rw=0 imm=8 rs2=%h",
                                  bus.out_valid, bus.out_regwrite, bus.out_imm, bus.out_rs2_val, wbv); end
    endtask

    task automatic test_backpressure();
        bundle_t held;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00700293;
        #1;
        step();
        held = ref_decode(32'h00700293);
        bus.in_instr  = 32'h00100313;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if ({bus.in_ready, bus.out_valid} !== 2'b01) begin bad++; $display("FAIL bp_handshake: got rdy=%b v=%b want rdy=0 v=1", bus.in_ready, bus.out_valid); end
            total++;
            if ({bus.out_rd, bus.out_imm, bus.out_regwrite} !== {held.rd, held.imm, held.rw})
                begin bad++; $display("FAIL bp_stable: got rd=%0d imm=%h want rd=%0d imm=%h", bus.out_rd, bus.out_imm, held.rd, held.imm); end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_resume_ready: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_rd, bus.out_imm} !== {5'd6, 64'd1}) begin bad++; $display("FAIL bp_next: got rd=%0d imm=%h want rd=6 imm=1", bus.out_rd, bus.out_imm); end
    endtask

    task automatic test_reset_mid_stall();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h000283B3;  // add x7,x5,x0 with x5 still busy
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_stall_ready: got %b want 0", bus.in_ready); end
        step();
        rst = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_high_ready: got %b want 0", bus.in_ready); end
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, dut_bundle()} !== {1'b0, bundle_t'(0)}) begin bad++; $display("FAIL rst_stall_clear: got v=%b %h want all 0", bus.out_valid, dut_bundle()); end
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_stall_release: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.out_rd} !== {1'b1, 5'd7}) begin bad++; $display("FAIL rst_stall_accept: got v=%b rd=%0d want v=1 rd=7", bus.out_valid, bus.out_rd); end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [13];
        logic [31:0] w;
        ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0F};
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 12)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic test_random();
        int nb, pick;
        rst = 1'b1;
        drive_idle();
        step();
        rst = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (!bus.in_valid || last_acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_instr = rand_instr();
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.wb_valid  = 1'b0;
            nb = $countones(m_busy);
            if (nb != 0 && $urandom_range(0, 2) == 0) begin
                pick = $urandom_range(0, nb - 1);
                for (int r = 1; r < 32; r++) begin
                    if (m_busy[r]) begin
                        if (pick == 0) begin
                            bus.wb_valid = 1'b1;
                            bus.wb_rd    = 5'(r);
                            bus.wb_data  = {$urandom, $urandom};
                        end
                        pick--;
                    end
                end
            end
            #1;
            total++;
            if (bus.in_ready !== model_ready()) begin bad++; $display("FAIL rand_in_ready: cycle %0d got %b want %b", c, bus.in_ready, model_ready()); end
            total++;
            if ({bus.register1, bus.register2} !== {bus.in_instr[19:15], bus.in_instr[24:20]})
                begin bad++; $display("FAIL rand_regaddr: got %0d %0d want %0d %0d", bus.register1, bus.register2, bus.in_instr[19:15], bus.in_instr[24:20]); end
            step();
            total++;
            if (bus.out_valid !== m_valid) begin bad++; $display("FAIL rand_out_valid: cycle %0d got %b want %b", c, bus.out_valid, m_valid); end
            if (m_valid) begin
                total++;
                if (dut_bundle() !== m_out) begin bad++; $display("FAIL rand_bundle: cycle %0d got %h want %h", c, dut_bundle(), m_out); end
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_raw_stall();
        test_neg_imm();
        test_store();
        test_backpressure();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
